placar_bcd: RTL and testbench

// - Next-generation Breakout scoreboard: N-digit BCD score, M-digit lives, game FSM, bonus lives.
// - Counts directly in BCD (no binary-to-BCD step); drives active-low 7-segment digits with leading-zero blanking.
// - Sits between the game-logic event flags (ball/paddle/block) and the board 7-segment displays.

---
 rtl/placar_pkg.sv | 34 +++
 rtl/bcd_digit_add.sv | 16 +
 rtl/placar_bcd.sv | 219 +++++++++++++++++++++
 tb/tb_placar_bcd.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/placar_pkg.sv
// Shared definitions for the Breakout BCD scoreboard: game states, blank segment code and digit decoders.
package placar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_LOST = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'h40;
      4'd1:    bcd_to_seg = 7'h79;
      4'd2:    bcd_to_seg = 7'h24;
      4'd3:    bcd_to_seg = 7'h30;
      4'd4:    bcd_to_seg = 7'h19;
      4'd5:    bcd_to_seg = 7'h12;
      4'd6:    bcd_to_seg = 7'h02;
      4'd7:    bcd_to_seg = 7'h78;
      4'd8:    bcd_to_seg = 7'h00;
      4'd9:    bcd_to_seg = 7'h10;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
    bin_to_bcd2 = {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit adder stage; stages are chained through carry to build a multi-digit score adder.
module bcd_digit_add (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_digit,
  output logic       o_carry
);

  logic [4:0] w_sum;

  assign w_sum   = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_cin};
  assign o_carry = (w_sum > 5'd9);
  assign o_digit = o_carry ? 4'(w_sum - 5'd10) : w_sum[3:0];

endmodule

// File: rtl/placar_bcd.sv
// Breakout scoreboard: BCD score/lives, game FSM, bonus lives and blanked 7-segment drive.
// Optional best-score register enabled by defining PLACAR_HISCORE_EN.
module placar_bcd
  import placar_pkg::*;
#(
  parameter int SCORE_DIGITS  = 4,
  parameter int LIFE_DIGITS   = 2,
  parameter int INIT_LIVES    = 3,
  parameter int MAX_LIVES     = 9,
  parameter int PTS_PER_BLOCK = 1,
  parameter int BONUS_EVERY   = 50
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      hit_block,
  input  logic                      lost_ball,
  input  logic                      block_bottom,
  input  logic                      start,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [4*LIFE_DIGITS-1:0]  lives_bcd,
  output logic [7*SCORE_DIGITS-1:0] seg_score,
  output logic [7*LIFE_DIGITS-1:0]  seg_lives,
  output logic [4*SCORE_DIGITS-1:0] hiscore_bcd,
  output logic [1:0]                game_state
);

  localparam int SW    = 4 * SCORE_DIGITS;
  localparam int BLK_W = (BONUS_EVERY > 1) ? $clog2(BONUS_EVERY) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'((BONUS_EVERY > 0) ? BONUS_EVERY - 1 : 0);
  localparam logic [6:0]       LIVES_INIT = 7'(INIT_LIVES);
  localparam logic [6:0]       LIVES_MAX  = 7'(MAX_LIVES);

  logic r_hit_q, r_lost_q, r_bottom_q, r_start_q;
  logic w_hit_ev, w_lost_ev, w_bottom_ev, w_start_ev;

  state_t                  r_state, w_state_next;
  logic [SW-1:0]           r_score, w_score_next, w_score_sum, w_score_inc;
  logic [6:0]              r_lives, w_lives_next, w_lives_bonus;
  logic [BLK_W-1:0]        r_blk, w_blk_next;
  logic [SCORE_DIGITS:0]   w_carry;
  logic [7:0]              w_lives_bcd8;
  logic [4*LIFE_DIGITS-1:0] r_lives_bcd, w_lives_digits;
  logic [7*SCORE_DIGITS-1:0] r_seg_score, w_seg_score_next;
  logic [7*LIFE_DIGITS-1:0]  r_seg_lives, w_seg_lives_next;
  logic w_score_lead, w_lives_lead;

  assign w_hit_ev    = hit_block & ~r_hit_q;
  assign w_lost_ev   = lost_ball & ~r_lost_q;
  assign w_bottom_ev = block_bottom & ~r_bottom_q;
  assign w_start_ev  = start & ~r_start_q;

  // Input history for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hit_q    <= 1'b0;
      r_lost_q   <= 1'b0;
      r_bottom_q <= 1'b0;
      r_start_q  <= 1'b0;
    end else begin
      r_hit_q    <= hit_block;
      r_lost_q   <= lost_ball;
      r_bottom_q <= block_bottom;
      r_start_q  <= start;
    end
  end

  assign w_carry[0] = 1'b0;
  for (genvar g = 0; g < SCORE_DIGITS; g++) begin : g_add
    bcd_digit_add u_add (
      .i_a     (r_score[4*g +: 4]),
      .i_b     ((g == 0) ? 4'(PTS_PER_BLOCK) : 4'd0),
      .i_cin   (w_carry[g]),
      .o_digit (w_score_sum[4*g +: 4]),
      .o_carry (w_carry[g+1])
    );
  end

  assign w_score_inc   = w_carry[SCORE_DIGITS] ? {SCORE_DIGITS{4'h9}} : w_score_sum;
  assign w_lives_bonus = (r_lives >= LIVES_MAX) ? r_lives : r_lives + 7'd1;

  // Game FSM next state; only PLAY accepts events, with bottom > lost > hit.
  always_comb begin
    w_state_next = r_state;
    w_score_next = r_score;
    w_lives_next = r_lives;
    w_blk_next   = r_blk;
    if (reset) begin
      w_state_next = ST_IDLE;
      w_score_next = {SW{1'b0}};
      w_lives_next = LIVES_INIT;
      w_blk_next   = {BLK_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_next = ST_PLAY;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (w_bottom_ev) begin
            w_state_next = ST_OVER;
            w_lives_next = 7'd0;
          end else if (w_lost_ev) begin
            if (r_lives <= 7'd1) begin
              w_state_next = ST_OVER;
              w_lives_next = 7'd0;
            end else begin
              w_state_next = ST_LOST;
              w_lives_next = r_lives - 7'd1;
            end
          end else if (w_hit_ev) begin
            w_score_next = w_score_inc;
            if (BONUS_EVERY == 0) begin
              w_blk_next = r_blk;
            end else if (r_blk == BLK_LAST) begin
              w_blk_next   = {BLK_W{1'b0}};
              w_lives_next = w_lives_bonus;
            end else begin
              w_blk_next = r_blk + 1'b1;
            end
          end else begin
            w_state_next = ST_PLAY;
          end
        end
        ST_LOST: begin
          if (!start) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_LOST;
          end
        end
        ST_OVER: begin
          if (w_start_ev) begin
            w_state_next = ST_PLAY;
            w_score_next = {SW{1'b0}};
            w_lives_next = LIVES_INIT;
            w_blk_next   = {BLK_W{1'b0}};
          end else begin
            w_state_next = ST_OVER;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign w_lives_bcd8   = bin_to_bcd2(w_lives_next);
  assign w_lives_digits = w_lives_bcd8[4*LIFE_DIGITS-1:0];

  // Segment decode with leading-zero blanking, scanning from the most significant digit.
  always_comb begin
    w_seg_score_next = {(7*SCORE_DIGITS){1'b1}};
    w_seg_lives_next = {(7*LIFE_DIGITS){1'b1}};
    w_score_lead     = 1'b1;
    w_lives_lead     = 1'b1;
    for (int i = SCORE_DIGITS - 1; i >= 0; i--) begin
      if (w_score_lead && (i != 0) && (w_score_next[4*i +: 4] == 4'd0)) begin
        w_seg_score_next[7*i +: 7] = SEG_BLANK;
      end else begin
        w_seg_score_next[7*i +: 7] = bcd_to_seg(w_score_next[4*i +: 4]);
        w_score_lead = 1'b0;
      end
    end
    for (int i = LIFE_DIGITS - 1; i >= 0; i--) begin
      if (w_lives_lead && (i != 0) && (w_lives_digits[4*i +: 4] == 4'd0)) begin
        w_seg_lives_next[7*i +: 7] = SEG_BLANK;
      end else begin
        w_seg_lives_next[7*i +: 7] = bcd_to_seg(w_lives_digits[4*i +: 4]);
        w_lives_lead = 1'b0;
      end
    end
  end

  // State, counters and display registers.
  always_ff @(posedge clock) begin
    r_state     <= w_state_next;
    r_score     <= w_score_next;
    r_lives     <= w_lives_next;
    r_blk       <= w_blk_next;
    r_lives_bcd <= w_lives_digits;
    r_seg_score <= w_seg_score_next;
    r_seg_lives <= w_seg_lives_next;
  end

  assign score_bcd  = r_score;
  assign lives_bcd  = r_lives_bcd;
  assign seg_score  = r_seg_score;
  assign seg_lives  = r_seg_lives;
  assign game_state = r_state;

`ifdef PLACAR_HISCORE_EN
  logic [SW-1:0] r_hiscore, w_hiscore_next;

  // Packed BCD orders like an unsigned number, so a plain compare is MS-digit first.
  always_comb begin
    if (reset) begin
      w_hiscore_next = {SW{1'b0}};
    end else if ((w_state_next == ST_OVER) && (r_state != ST_OVER) && (r_score > r_hiscore)) begin
      w_hiscore_next = r_score;
    end else begin
      w_hiscore_next = r_hiscore;
    end
  end

  // Best-score register, survives new games.
  always_ff @(posedge clock) begin
    r_hiscore <= w_hiscore_next;
  end

  assign hiscore_bcd = r_hiscore;
`else
  assign hiscore_bcd = {SW{1'b0}};
`endif

endmodule

// File: tb/tb_placar_bcd.sv
// Scoreboard bench for placar_bcd: default instance plus a 2-digit, 9-point, bonus-every-5 instance.
module tb_placar_bcd;

`ifdef PLACAR_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, hit_block, lost_ball, block_bottom, start;
  logic hit2, lost2, bottom2, start2;

  logic [15:0] score_bcd, hiscore_bcd;
  logic [7:0]  lives_bcd;
  logic [27:0] seg_score;
  logic [13:0] seg_lives;
  logic [1:0]  game_state;

  logic [7:0]  score2, hiscore2, lives2;
  logic [13:0] seg_score2, seg_lives2;
  logic [1:0]  state2;

  int n_checks = 0;
  int n_errors = 0;

  string       q_tag[$];
  int          q_sel[$];
  logic [31:0] q_val[$];

  always #5 clock = ~clock;

  placar_bcd u_dut (
    .clock(clock), .reset(reset), .hit_block(hit_block), .lost_ball(lost_ball),
    .block_bottom(block_bottom), .start(start), .score_bcd(score_bcd), .lives_bcd(lives_bcd),
    .seg_score(seg_score), .seg_lives(seg_lives), .hiscore_bcd(hiscore_bcd), .game_state(game_state)
  );

  placar_bcd #(.SCORE_DIGITS(2), .PTS_PER_BLOCK(9), .BONUS_EVERY(5)) u_dut2 (
    .clock(clock), .reset(reset), .hit_block(hit2), .lost_ball(lost2),
    .block_bottom(bottom2), .start(start2), .score_bcd(score2), .lives_bcd(lives2),
    .seg_score(seg_score2), .seg_lives(seg_lives2), .hiscore_bcd(hiscore2), .game_state(state2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       observe = {16'h0, score_bcd};
      1:       observe = {24'h0, lives_bcd};
      2:       observe = {30'h0, game_state};
      3:       observe = {4'h0, seg_score};
      4:       observe = {18'h0, seg_lives};
      5:       observe = {16'h0, hiscore_bcd};
      6:       observe = {24'h0, score2};
      7:       observe = {24'h0, lives2};
      8:       observe = {18'h0, seg_score2};
      9:       observe = {24'h0, hiscore2};
      10:      observe = {30'h0, state2};
      default: observe = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
    q_tag.push_back(tag);
    q_sel.push_back(sel);
    q_val.push_back(val);
  endtask

  // One clock; then every pending expectation is popped and compared.
  task automatic settle();
    string       t;
    int          s;
    logic [31:0] v;
    @(posedge clock);
    #1;
    while (q_tag.size() > 0) begin
      t = q_tag.pop_front();
      s = q_sel.pop_front();
      v = q_val.pop_front();
      check_eq(t, observe(s), v);
    end
  endtask

  task automatic pulse_hit(input int n);
    for (int i = 0; i < n; i++) begin
      hit_block = 1'b1; settle();
      hit_block = 1'b0; settle();
    end
  endtask

  task automatic pulse_hit2(input int n);
    for (int i = 0; i < n; i++) begin
      hit2 = 1'b1; settle();
      hit2 = 1'b0; settle();
    end
  endtask

  task automatic pulse_lost();
    lost_ball = 1'b1; settle();
    lost_ball = 1'b0; settle();
  endtask

  initial begin
    reset = 1'b1; hit_block = 1'b0; lost_ball = 1'b0; block_bottom = 1'b0; start = 1'b0;
    hit2 = 1'b0; lost2 = 1'b0; bottom2 = 1'b0; start2 = 1'b0;
    settle(); settle();
    reset = 1'b0;
    expect_val("rst_score", 0, 32'h0000);
    expect_val("rst_lives", 1, 32'h03);
    expect_val("rst_state", 2, 32'd0);
    expect_val("rst_seg_score", 3, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    expect_val("rst_seg_lives", 4, {18'h0, 7'h7F, 7'h30});
    expect_val("rst_hiscore", 5, 32'h0000);
    settle();

    start = 1'b1;
    expect_val("start_play", 2, 32'd1);
    settle();

    // Three single hits; the last one is checked one cycle after its event.
    pulse_hit(2);
    hit_block = 1'b1;
    expect_val("hit3_score", 0, 32'h0003);
    expect_val("hit3_seg", 3, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h30});
    expect_val("hit3_state", 2, 32'd1);
    settle();
    hit_block = 1'b0; settle();

    hit_block = 1'b1;
    repeat (20) settle();
    hit_block = 1'b0;
    expect_val("held_hit_once", 0, 32'h0004);
    settle();

    pulse_hit(38);
    expect_val("score_42", 0, 32'h0042);
    expect_val("seg_42", 3, {4'h0, 7'h7F, 7'h7F, 7'h19, 7'h24});
    settle();

    lost_ball = 1'b1;
    expect_val("lost1_lives", 1, 32'h02);
    expect_val("lost1_state", 2, 32'd2);
    settle();
    lost_ball = 1'b0; settle();

    hit_block = 1'b1; settle(); hit_block = 1'b0;
    expect_val("hit_in_lost", 0, 32'h0042);
    settle();

    start = 1'b0;
    expect_val("lost_to_idle", 2, 32'd0);
    settle();
    start = 1'b1;
    expect_val("idle_to_play", 2, 32'd1);
    settle();

    lost_ball = 1'b1;
    expect_val("lost2_lives", 1, 32'h01);
    expect_val("lost2_state", 2, 32'd2);
    settle();
    lost_ball = 1'b0; settle();
    start = 1'b0; settle();
    start = 1'b1; settle();

    lost_ball = 1'b1;
    expect_val("lost3_lives", 1, 32'h00);
    expect_val("lost3_state", 2, 32'd3);
    expect_val("lost3_seg_lives", 4, {18'h0, 7'h7F, 7'h40});
    settle();
    lost_ball = 1'b0;
    expect_val("hiscore_game1", 5, HI_EN ? 32'h0042 : 32'h0000);
    settle();

    start = 1'b0; settle();
    start = 1'b1;
    expect_val("newgame_score", 0, 32'h0000);
    expect_val("newgame_lives", 1, 32'h03);
    expect_val("newgame_state", 2, 32'd1);
    settle();

    lost_ball = 1'b1; hit_block = 1'b1;
    expect_val("lost_hit_lives", 1, 32'h02);
    expect_val("lost_hit_score", 0, 32'h0000);
    expect_val("lost_hit_state", 2, 32'd2);
    settle();
    lost_ball = 1'b0; hit_block = 1'b0; settle();
    start = 1'b0; settle();
    start = 1'b1; settle();

    pulse_hit(17);
    expect_val("score_17", 0, 32'h0017);
    expect_val("seg_17", 3, {4'h0, 7'h7F, 7'h7F, 7'h79, 7'h78});
    settle();

    block_bottom = 1'b1; lost_ball = 1'b1;
    expect_val("bottom_state", 2, 32'd3);
    expect_val("bottom_lives", 1, 32'h00);
    settle();
    block_bottom = 1'b0; lost_ball = 1'b0;
    expect_val("hiscore_game2", 5, HI_EN ? 32'h0042 : 32'h0000);
    settle();

    reset = 1'b1;
    expect_val("rst2_hiscore", 5, 32'h0000);
    expect_val("rst2_score", 0, 32'h0000);
    expect_val("rst2_state", 2, 32'd0);
    expect_val("rst2_lives", 1, 32'h03);
    settle();
    reset = 1'b0; settle();

    // Second instance: 9 points per hit, bonus life every 5 hits, 2-digit saturation.
    start2 = 1'b1; settle();
    pulse_hit2(4);
    hit2 = 1'b1;
    expect_val("d2_score_45", 6, 32'h45);
    expect_val("d2_bonus1", 7, 32'h04);
    settle();
    hit2 = 1'b0; settle();
    pulse_hit2(5);
    expect_val("d2_score_90", 6, 32'h90);
    expect_val("d2_bonus2", 7, 32'h05);
    settle();
    pulse_hit2(2);
    expect_val("d2_score_sat", 6, 32'h99);
    expect_val("d2_lives_end", 7, 32'h05);
    expect_val("d2_seg_99", 8, {18'h0, 7'h10, 7'h10});
    expect_val("d2_hiscore", 9, 32'h00);
    expect_val("d2_state", 10, 32'd1);
    settle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
